hyper_cmd_seq: RTL

Upstream command sequencer for the HyperRAM controller. Accepts host transaction requests, builds the 48-bit HyperBus command/address word, and launches exactly one of the four transaction state machines (read-memory, write-memory, read-register, write-register). It then waits for that machine's end pulse and enforces the minimum CS# deassert time before accepting the next request.

---
 rtl/hyper_cmd_seq.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/hyper_cmd_seq.sv
// HyperRAM command sequencer: builds the 48-bit CA word, launches one transaction machine, waits for its end, enforces CS# high time.
// Optional watchdog on WAIT_END compiled in with HYPER_CMD_TIMEOUT_EN.
module hyper_cmd_seq #(
    parameter int unsigned CSHI_CYCLES    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic        req_linear,
    output logic [47:0] casig,
    output logic        start_rdmem,
    output logic        start_wrmem,
    output logic        start_rdreg,
    output logic        start_wrreg,
    input  logic        end_rdmem,
    input  logic        end_wrmem,
    input  logic        end_rdreg,
    input  logic        end_wrreg,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int CNT_W = (CSHI_CYCLES > 1) ? $clog2(CSHI_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LAUNCH   = 2'd1,
        ST_WAIT_END = 2'd2,
        ST_RECOVER  = 2'd3
    } state_t;

    state_t             state_r;
    logic               req_ready_r;
    logic [47:0]        casig_r;
    logic [3:0]         start_r;
    logic               busy_r;
    logic               done_r;
    logic               err_r;
    logic [1:0]         op_r;
    logic [CNT_W-1:0]   rec_cnt_r;
    logic               end_match_s;
`ifdef HYPER_CMD_TIMEOUT_EN
    logic [15:0]        wd_r;
    logic               wd_expire_s;
`endif

    function automatic logic [47:0] build_casig(input logic [1:0] op,
                                                input logic [31:0] addr,
                                                input logic linear);
        build_casig = {~op[0], op[1], linear, addr[31:3], 13'd0, addr[2:0]};
    endfunction

    // start vector order: {wrreg, rdreg, wrmem, rdmem}
    function automatic logic [3:0] op_onehot(input logic [1:0] op);
        case (op)
            2'b00:   op_onehot = 4'b0001;
            2'b01:   op_onehot = 4'b0010;
            2'b10:   op_onehot = 4'b0100;
            2'b11:   op_onehot = 4'b1000;
            default: op_onehot = 4'b0000;
        endcase
    endfunction

    // Select the end pulse belonging to the transaction in flight
    always_comb begin
        end_match_s = 1'b0;
        case (op_r)
            2'b00:   end_match_s = end_rdmem;
            2'b01:   end_match_s = end_wrmem;
            2'b10:   end_match_s = end_rdreg;
            2'b11:   end_match_s = end_wrreg;
            default: end_match_s = 1'b0;
        endcase
    end

`ifdef HYPER_CMD_TIMEOUT_EN
    assign wd_expire_s = (wd_r == 16'(TIMEOUT_CYCLES - 1));
`endif

    // Sequencer FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            req_ready_r <= 1'b0;
            casig_r     <= 48'd0;
            start_r     <= 4'b0000;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            op_r        <= 2'b00;
            rec_cnt_r   <= '0;
`ifdef HYPER_CMD_TIMEOUT_EN
            wd_r        <= 16'd0;
`endif
        end else begin
            start_r <= 4'b0000;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_valid && req_ready_r) begin
                        op_r        <= req_op;
                        casig_r     <= build_casig(req_op, req_addr, req_linear);
                        start_r     <= op_onehot(req_op);
                        req_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        state_r     <= ST_LAUNCH;
                    end else begin
                        req_ready_r <= 1'b1;
                    end
                end
                ST_LAUNCH: begin
                    // end pulses coincident with start are deliberately not looked at here
                    state_r <= ST_WAIT_END;
`ifdef HYPER_CMD_TIMEOUT_EN
                    wd_r    <= 16'd0;
`endif
                end
                ST_WAIT_END: begin
                    if (end_match_s) begin
                        done_r    <= 1'b1;
                        rec_cnt_r <= CNT_W'(CSHI_CYCLES - 1);
                        state_r   <= ST_RECOVER;
                    end
`ifdef HYPER_CMD_TIMEOUT_EN
                    else if (wd_expire_s) begin
                        done_r    <= 1'b1;
                        err_r     <= 1'b1;
                        rec_cnt_r <= CNT_W'(CSHI_CYCLES - 1);
                        state_r   <= ST_RECOVER;
                    end else begin
                        wd_r <= wd_r + 16'd1;
                    end
`else
                    else begin
                        state_r <= ST_WAIT_END;
                    end
`endif
                end
                ST_RECOVER: begin
                    if (rec_cnt_r == '0) begin
                        state_r     <= ST_IDLE;
                        busy_r      <= 1'b0;
                        req_ready_r <= 1'b1;
                    end else begin
                        rec_cnt_r <= rec_cnt_r - 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    busy_r      <= 1'b0;
                    req_ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_r;
    assign casig       = casig_r;
    assign start_rdmem = start_r[0];
    assign start_wrmem = start_r[1];
    assign start_rdreg = start_r[2];
    assign start_wrreg = start_r[3];
    assign busy        = busy_r;
    assign done        = done_r;
    assign err         = err_r;

endmodule
